// File: rtl/ncpu32k_ifu_pq_if.sv
// Bundle between the prefetch fetch unit, its instruction bus, the predecoder and the IDU.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid
// never waits for ready, and ibus_cmd_addr stays put while valid & ~ready unless redirected.
interface ncpu32k_ifu_pq_if #(
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ibus_cmd_valid;
  logic          ibus_cmd_ready;
  logic [AW-1:0] ibus_cmd_addr;
  logic          ibus_rsp_valid;
  logic          ibus_rsp_ready;
  logic [IW-1:0] ibus_rsp_insn;
  logic [IW-1:0] pdu_insn;
  logic          pdu_jmprel_taken;
  logic [AW-3:0] pdu_jmprel_offset;
  logic          pdu_jmprel_link;
  logic          pdu_op_jmprel;
  logic          ifu_jmpfar;
  logic [AW-3:0] ifu_jmpfar_addr;
  logic          idu_in_valid;
  logic          idu_in_ready;
  logic [IW-1:0] idu_insn;
  logic [AW-3:0] idu_insn_pc;
  logic          idu_jmprel_link;
  logic          idu_op_jmprel;
  logic [CW-1:0] dbg_outst;
  logic [CW-1:0] dbg_count;
  logic [CW-1:0] dbg_drop_cnt;

  modport master (
    output ibus_cmd_valid, ibus_cmd_addr, ibus_rsp_ready, pdu_insn,
           idu_in_valid, idu_insn, idu_insn_pc, idu_jmprel_link, idu_op_jmprel,
           dbg_outst, dbg_count, dbg_drop_cnt,
    input  ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_insn,
           pdu_jmprel_taken, pdu_jmprel_offset, pdu_jmprel_link, pdu_op_jmprel,
           ifu_jmpfar, ifu_jmpfar_addr, idu_in_ready
  );

  modport slave (
    input  ibus_cmd_valid, ibus_cmd_addr, ibus_rsp_ready, pdu_insn,
           idu_in_valid, idu_insn, idu_insn_pc, idu_jmprel_link, idu_op_jmprel,
           dbg_outst, dbg_count, dbg_drop_cnt,
    output ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_insn,
           pdu_jmprel_taken, pdu_jmprel_offset, pdu_jmprel_link, pdu_op_jmprel,
           ifu_jmpfar, ifu_jmpfar_addr, idu_in_ready
  );
endinterface

// File: rtl/ncpu32k_ifu_pq.sv
// Prefetching instruction fetch unit: credit-limited in-order fetch, DEPTH-entry queue to the
// IDU, redirect on taken relative jumps and far jumps, wrong-path responses dropped by count.
module ncpu32k_ifu_pq #(
  parameter int            AW          = 32,
  parameter int            IW          = 32,
  parameter int            DEPTH       = 4,
  parameter logic [AW-1:0] ERST_VECTOR = '0
) (
  input logic               clk,
  input logic               rst_n,
  ncpu32k_ifu_pq_if.master  bus
);
  localparam int PW   = AW - 2;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int PTRW = $clog2(DEPTH);
  localparam int EW   = IW + PW + 2;

  localparam logic [PW-1:0]   RST_PC  = ERST_VECTOR[AW-1:2];
  localparam logic [PW-1:0]   PC_ONE  = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);
  localparam logic [CW:0]     DEPTH_X = (CW+1)'(DEPTH);

  logic [PW-1:0]   fetch_pc, rsp_pc, rel_target;
  logic [CW-1:0]   outst, drop_cnt, count;
  logic [PTRW-1:0] rd_ptr, wr_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;

  logic rsp_fire, live, redir_rel, redirect, cmd_valid, issue, push, pop, head_valid;
  logic [CW-1:0] issue_w, fire_w, push_w, pop_w;

  assign rsp_fire   = bus.ibus_rsp_valid;
  assign live       = rsp_fire && (drop_cnt == '0);
  assign redir_rel  = live && bus.pdu_jmprel_taken && !bus.ifu_jmpfar;
  assign redirect   = bus.ifu_jmpfar || redir_rel;
  // Credits: every request in flight already owns a queue slot, so responses are never refused.
  assign cmd_valid  = !redirect && (({1'b0, outst} + {1'b0, count}) < DEPTH_X);
  assign issue      = cmd_valid && bus.ibus_cmd_ready;
  assign push       = live && !bus.ifu_jmpfar;
  assign head_valid = (count != '0);
  assign pop        = head_valid && bus.idu_in_ready;
  assign rel_target = rsp_pc + bus.pdu_jmprel_offset;

  assign issue_w = {{(CW-1){1'b0}}, issue};
  assign fire_w  = {{(CW-1){1'b0}}, rsp_fire};
  assign push_w  = {{(CW-1){1'b0}}, push};
  assign pop_w   = {{(CW-1){1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RST_PC;
      rsp_pc   <= RST_PC;
      outst    <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      outst <= outst + issue_w - fire_w;
      if (bus.ifu_jmpfar) begin
        fetch_pc <= bus.ifu_jmpfar_addr;
        rsp_pc   <= bus.ifu_jmpfar_addr;
        drop_cnt <= outst - fire_w;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_ONE;
        if (rsp_fire && !live) drop_cnt <= drop_cnt - CNT_ONE;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (redir_rel) begin
            // Everything still in flight besides this response is on the wrong path.
            fetch_pc <= rel_target;
            rsp_pc   <= rel_target;
            drop_cnt <= outst - CNT_ONE;
          end else begin
            rsp_pc <= rsp_pc + PC_ONE;
          end
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        count <= count + push_w - pop_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.ibus_rsp_insn, rsp_pc, bus.pdu_jmprel_link, bus.pdu_op_jmprel};
  end

  assign head = mem[rd_ptr];

  assign bus.ibus_cmd_valid  = cmd_valid;
  assign bus.ibus_cmd_addr   = {fetch_pc, 2'b00};
  assign bus.ibus_rsp_ready  = 1'b1;
  assign bus.pdu_insn        = bus.ibus_rsp_insn;
  assign bus.idu_in_valid    = head_valid;
  assign bus.idu_insn        = head_valid ? head[EW-1 -: IW] : '0;
  assign bus.idu_insn_pc     = head_valid ? head[PW+1 -: PW] : '0;
  assign bus.idu_jmprel_link = head_valid && head[1];
  assign bus.idu_op_jmprel   = head_valid && head[0];
  assign bus.dbg_outst       = outst;
  assign bus.dbg_count       = count;
  assign bus.dbg_drop_cnt    = drop_cnt;
endmodule

// File: tb/tb_ncpu32k_ifu_pq.sv
// Directed and random bench for ncpu32k_ifu_pq: in-order bus model with variable latency,
// a table-driven predecoder, and a scoreboard of the architectural PC stream.
module tb_ncpu32k_ifu_pq;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ncpu32k_ifu_pq_if #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) bus_if ();

  ncpu32k_ifu_pq #(.AW(AW), .IW(IW), .DEPTH(DEPTH), .ERST_VECTOR(32'h100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [W-1:0]  exp_q[$];
  logic [29:0]   bus_q[$];
  int            due_q[$];
  logic [31:0]   issue_addr[$];
  int            issue_cyc[$];
  int            deliv_cyc[$];

  // stimulus knobs
  int          lat_min = 1, lat_max = 1;
  bit          cmd_rand = 0, idu_rand = 0, idu_en = 1, check_inv = 0;
  bit          jmp_en = 0;
  logic [29:0] jmp_src = '0, jmp_off = '0;
  bit          far_req = 0;
  logic [29:0] far_addr = '0;
  logic        last_cmd_valid, last_idu_valid;
  logic [31:0] last_cmd_addr;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [29:0] pc);
    return {2'b10, pc};
  endfunction

  function automatic bit is_jmp(input logic [29:0] pc);
    return jmp_en && (pc == jmp_src);
  endfunction

  function automatic logic [W-1:0] mk_exp(input logic [29:0] pc);
    return {mk_insn(pc), pc, pc[1], is_jmp(pc)};
  endfunction

  task automatic push_stream(input logic [29:0] start, input int n);
    logic [29:0] pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk_exp(pc));
      pc = is_jmp(pc) ? pc + jmp_off : pc + 30'd1;
    end
  endtask

  // One clock: called at a falling edge, drives inputs, samples, returns at the next falling edge.
  task automatic cycle();
    logic [29:0] rpc;
    logic [W-1:0] obs;
    bit rv;
    rv = (bus_q.size() != 0) && (due_q[0] <= cyc);
    if (rv) begin
      rpc = bus_q[0];
      bus_if.ibus_rsp_valid    = 1'b1;
      bus_if.ibus_rsp_insn     = mk_insn(rpc);
      bus_if.pdu_jmprel_taken  = is_jmp(rpc);
      bus_if.pdu_op_jmprel     = is_jmp(rpc);
      bus_if.pdu_jmprel_link   = rpc[1];
      bus_if.pdu_jmprel_offset = is_jmp(rpc) ? jmp_off : 30'($urandom);
    end else begin
      bus_if.ibus_rsp_valid    = 1'b0;
      bus_if.ibus_rsp_insn     = $urandom;
      bus_if.pdu_jmprel_taken  = 1'($urandom);
      bus_if.pdu_op_jmprel     = 1'($urandom);
      bus_if.pdu_jmprel_link   = 1'($urandom);
      bus_if.pdu_jmprel_offset = 30'($urandom);
    end
    bus_if.ifu_jmpfar      = far_req;
    bus_if.ifu_jmpfar_addr = far_addr;
    bus_if.ibus_cmd_ready  = cmd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    bus_if.idu_in_ready    = idu_en && (exp_q.size() != 0) &&
                             (idu_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    #1;
    last_cmd_valid = bus_if.ibus_cmd_valid;
    last_cmd_addr  = bus_if.ibus_cmd_addr;
    last_idu_valid = bus_if.idu_in_valid;
    if (rv) begin
      void'(bus_q.pop_front());
      void'(due_q.pop_front());
    end
    if (bus_if.ibus_cmd_valid && bus_if.ibus_cmd_ready) begin
      bus_q.push_back(bus_if.ibus_cmd_addr[31:2]);
      due_q.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
      issue_addr.push_back(bus_if.ibus_cmd_addr);
      issue_cyc.push_back(cyc);
    end
    if (bus_if.idu_in_valid && bus_if.idu_in_ready) begin
      obs = {bus_if.idu_insn, bus_if.idu_insn_pc, bus_if.idu_jmprel_link, bus_if.idu_op_jmprel};
      deliv_cyc.push_back(cyc);
      chk("idu_entry", obs, exp_q.pop_front());
    end
    if (check_inv) begin
      chk("inv_credit", W'((32'(bus_if.dbg_outst) + 32'(bus_if.dbg_count)) <= DEPTH), W'(1));
      chk("inv_drop", W'(bus_if.dbg_drop_cnt <= bus_if.dbg_outst), W'(1));
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_empty(input string tag, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cycle();
      n++;
    end
    chk({"drain_", tag}, W'(exp_q.size()), W'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.ibus_rsp_valid = 1'b0;
    bus_if.ifu_jmpfar     = 1'b0;
    bus_if.ibus_cmd_ready = 1'b0;
    bus_if.idu_in_ready   = 1'b0;
    repeat (2) @(negedge clk);
    bus_q.delete(); due_q.delete(); exp_q.delete();
    issue_addr.delete(); issue_cyc.delete(); deliv_cyc.delete();
    cyc = 0; far_req = 0; jmp_en = 0; check_inv = 0;
    cmd_rand = 0; idu_rand = 0; idu_en = 1; lat_min = 1; lat_max = 1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_if.ibus_cmd_ready = 0; bus_if.ibus_rsp_valid = 0; bus_if.ibus_rsp_insn = '0;
    bus_if.pdu_jmprel_taken = 0; bus_if.pdu_jmprel_offset = '0; bus_if.pdu_jmprel_link = 0;
    bus_if.pdu_op_jmprel = 0; bus_if.ifu_jmpfar = 0; bus_if.ifu_jmpfar_addr = '0;
    bus_if.idu_in_ready = 0;

    // reset state
    do_reset();
    #1;
    chk("rst_idu_valid", W'(bus_if.idu_in_valid), W'(0));
    chk("rst_idu_insn", W'(bus_if.idu_insn), W'(0));
    chk("rst_idu_pc", W'(bus_if.idu_insn_pc), W'(0));
    chk("rst_idu_flags", W'({bus_if.idu_jmprel_link, bus_if.idu_op_jmprel}), W'(0));
    chk("rst_cmd_valid", W'(bus_if.ibus_cmd_valid), W'(1));
    chk("rst_cmd_addr", W'(bus_if.ibus_cmd_addr), W'(32'h100));
    chk("rst_rsp_ready", W'(bus_if.ibus_rsp_ready), W'(1));
    chk("rst_counters", W'({bus_if.dbg_outst, bus_if.dbg_count, bus_if.dbg_drop_cnt}), W'(0));

    // streaming, latency 1, IDU always ready
    push_stream(30'h40, 16);
    run_until_empty("stream", 100);
    for (int i = 0; i < 3; i++) begin
      chk("stream_issue_addr", W'(issue_addr[i]), W'(32'h100 + 32'(4 * i)));
      chk("stream_issue_cyc", W'(issue_cyc[i]), W'(i));
      chk("stream_deliv_cyc", W'(deliv_cyc[i]), W'(2 + i));
    end
    chk("stream_throughput", W'(deliv_cyc[15]), W'(17));

    // IDU stalled: credits cap the fetches at DEPTH
    do_reset();
    idu_en = 0;
    repeat (10) cycle();
    chk("stall_issues", W'(issue_addr.size()), W'(4));
    chk("stall_cmd_valid", W'(last_cmd_valid), W'(0));
    chk("stall_count", W'(bus_if.dbg_count), W'(4));
    push_stream(30'h40, 8);
    idu_en = 1;
    run_until_empty("stall_release", 100);
    chk("stall_resume_addr", W'(issue_addr[4]), W'(32'h110));

    // reset while busy
    idu_en = 0;
    repeat (6) cycle();
    do_reset();
    #1;
    chk("midrst_valid", W'(bus_if.idu_in_valid), W'(0));
    chk("midrst_counters", W'({bus_if.dbg_outst, bus_if.dbg_count, bus_if.dbg_drop_cnt}), W'(0));
    chk("midrst_cmd_addr", W'(bus_if.ibus_cmd_addr), W'(32'h100));

    // taken relative jump with 3 fetches in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    jmp_en = 1; jmp_src = 30'h40; jmp_off = 30'h10;
    push_stream(30'h40, 7);
    repeat (4) cycle();
    chk("rel_drop_cnt", W'(bus_if.dbg_drop_cnt), W'(2));
    run_until_empty("rel", 100);
    chk("rel_issue_n3", W'(issue_addr[2]), W'(32'h108));
    chk("rel_target_addr", W'(issue_addr[3]), W'(32'h140));

    // far jump with 2 queued, 2 in flight, one response arriving
    do_reset();
    lat_min = 3; lat_max = 3; idu_en = 0;
    repeat (5) cycle();
    chk("far_pre_count", W'(bus_if.dbg_count), W'(2));
    chk("far_pre_outst", W'(bus_if.dbg_outst), W'(2));
    far_req = 1; far_addr = 30'h200;
    cycle();
    far_req = 0;
    chk("far_drop_cnt", W'(bus_if.dbg_drop_cnt), W'(1));
    cycle();
    chk("far_idu_valid", W'(last_idu_valid), W'(0));
    chk("far_cmd", W'({last_cmd_valid, last_cmd_addr}), W'({1'b1, 32'h800}));
    chk("far_drop_done", W'(bus_if.dbg_drop_cnt), W'(0));
    push_stream(30'h200, 6);
    idu_en = 1;
    run_until_empty("far", 100);

    // far jump in the same cycle as a taken relative jump
    do_reset();
    jmp_en = 1; jmp_src = 30'h42; jmp_off = 30'h20;
    push_stream(30'h40, 2);
    repeat (3) cycle();
    far_req = 1; far_addr = 30'h300;
    cycle();
    far_req = 0;
    push_stream(30'h300, 4);
    run_until_empty("far_vs_rel", 100);
    chk("far_vs_rel_addr", W'(issue_addr[3]), W'(32'hC00));

    // random latency and back-pressure around a backward loop
    do_reset();
    lat_min = 1; lat_max = 5; cmd_rand = 1; idu_rand = 1; check_inv = 1;
    jmp_en = 1; jmp_src = 30'h47; jmp_off = 30'h3FFF_FFF9;
    push_stream(30'h40, 40);
    run_until_empty("random", 3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
